// File: rtl/bldcm_deadtime.sv
// -----------------------------------------------------------------------------
// bldcm_deadtime
//   Gate-drive conditioner between the BLDC drive core and the inverter gate
//   pins. For each phase (U/V/W) it inserts a programmable dead time whenever
//   drive moves from one side of the half-bridge to the other. It latches a
//   shoot-through fault when both sides of any phase are requested together,
//   and applies a fixed per-pin output polarity.
//
// Ports
//   iClock            system clock, rising edge
//   iReset_n          asynchronous active-low reset
//   iUh..iWl          logical drive requests, active-high
//   iDeadCycles       dead time in cycles, sampled when a counter loads
//   iFaultClear       level; clears the latched fault when no phase requests 11
//   oUh..oWl          physical gate drives (logical value XOR pInvert*)
//   oFault            shoot-through fault latched
//   oFaultPhase       sticky fault source mask {W,V,U}
// -----------------------------------------------------------------------------
module bldcm_deadtime #(
  parameter int   pDeadWidth = 8,
  parameter logic pInvertUh  = 1'b0,
  parameter logic pInvertUl  = 1'b0,
  parameter logic pInvertVh  = 1'b0,
  parameter logic pInvertVl  = 1'b0,
  parameter logic pInvertWh  = 1'b0,
  parameter logic pInvertWl  = 1'b0
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic                  iUh,
  input  logic                  iUl,
  input  logic                  iVh,
  input  logic                  iVl,
  input  logic                  iWh,
  input  logic                  iWl,
  input  logic [pDeadWidth-1:0] iDeadCycles,
  input  logic                  iFaultClear,
  output logic                  oUh,
  output logic                  oUl,
  output logic                  oVh,
  output logic                  oVl,
  output logic                  oWh,
  output logic                  oWl,
  output logic                  oFault,
  output logic [2:0]            oFaultPhase
);

  typedef enum logic [1:0] {ST_OFF, ST_ON_H, ST_ON_L} state_t;
  typedef enum logic [1:0] {LAST_NONE, LAST_H, LAST_L, LAST_BOTH} last_t;

  localparam logic [pDeadWidth-1:0] cnt_one = 1;

  // Index 0 = U, 1 = V, 2 = W throughout.
  logic [2:0] req_h;
  logic [2:0] req_l;
  logic [2:0] shoot;
  logic       fault_set;

  assign req_h     = {iWh, iVh, iUh};
  assign req_l     = {iWl, iVl, iUl};
  assign shoot     = req_h & req_l;
  assign fault_set = |shoot;

  state_t                st_q   [3];
  state_t                st_d   [3];
  logic [pDeadWidth-1:0] cnt_q  [3];
  logic [pDeadWidth-1:0] cnt_d  [3];
  last_t                 last_q [3];
  last_t                 last_d [3];
  logic                  fault_q;
  logic                  fault_d;
  logic [2:0]            phase_q;
  logic [2:0]            phase_d;

  // NOTE: every next-state signal takes its hold value first so no path
  // through the case statements leaves a variable unassigned (no latches).
  always_comb begin
    fault_d = fault_q;
    phase_d = phase_q;
    // Setting a fault wins over clearing it on the same edge.
    if (fault_set) begin
      fault_d = 1'b1;
      phase_d = phase_q | shoot;
    end else if (fault_q && iFaultClear) begin
      fault_d = 1'b0;
      phase_d = '0;
    end

    for (int p = 0; p < 3; p++) begin
      st_d[p]   = st_q[p];
      last_d[p] = last_q[p];
      // Free-running saturating countdown; overridden below whenever it loads.
      cnt_d[p]  = (cnt_q[p] != '0) ? cnt_q[p] - cnt_one : '0;

      if (fault_set) begin
        // A fault edge re-arms every phase, including those already off.
        st_d[p]   = ST_OFF;
        cnt_d[p]  = iDeadCycles;
        last_d[p] = LAST_BOTH;
      end else if (fault_q) begin
        // Latched fault (including the clearing edge): gates stay off.
        st_d[p] = ST_OFF;
      end else begin
        unique case ({req_h[p], req_l[p]})
          2'b00: begin
            if (st_q[p] != ST_OFF) begin
              st_d[p]   = ST_OFF;
              cnt_d[p]  = iDeadCycles;
              last_d[p] = (st_q[p] == ST_ON_H) ? LAST_H : LAST_L;
            end
          end
          2'b10: begin
            if (st_q[p] == ST_OFF) begin
              // Same-side re-enable skips the dead time; cnt<=1 means the
              // final dead cycle is being spent on this edge.
              if (last_q[p] == LAST_NONE || last_q[p] == LAST_H ||
                  cnt_q[p] <= cnt_one)
                st_d[p] = ST_ON_H;
            end else if (st_q[p] == ST_ON_L) begin
              st_d[p]   = ST_OFF;
              cnt_d[p]  = iDeadCycles;
              last_d[p] = LAST_L;
            end
          end
          2'b01: begin
            if (st_q[p] == ST_OFF) begin
              if (last_q[p] == LAST_NONE || last_q[p] == LAST_L ||
                  cnt_q[p] <= cnt_one)
                st_d[p] = ST_ON_L;
            end else if (st_q[p] == ST_ON_H) begin
              st_d[p]   = ST_OFF;
              cnt_d[p]  = iDeadCycles;
              last_d[p] = LAST_H;
            end
          end
          default: ; // 11 is handled as a fault above
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      // NOTE: the per-phase arrays are control state, not storage, so every
      // element is reset; outputs must be inactive the instant reset asserts.
      for (int p = 0; p < 3; p++) begin
        st_q[p]   <= ST_OFF;
        cnt_q[p]  <= '0;
        last_q[p] <= LAST_NONE;
      end
      fault_q <= 1'b0;
      phase_q <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        st_q[p]   <= st_d[p];
        cnt_q[p]  <= cnt_d[p];
        last_q[p] <= last_d[p];
      end
      fault_q <= fault_d;
      phase_q <= phase_d;
    end
  end

  // Gate drives decode directly from the state flops; polarity is constant.
  assign oUh = (st_q[0] == ST_ON_H) ^ pInvertUh;
  assign oUl = (st_q[0] == ST_ON_L) ^ pInvertUl;
  assign oVh = (st_q[1] == ST_ON_H) ^ pInvertVh;
  assign oVl = (st_q[1] == ST_ON_L) ^ pInvertVl;
  assign oWh = (st_q[2] == ST_ON_H) ^ pInvertWh;
  assign oWl = (st_q[2] == ST_ON_L) ^ pInvertWl;

  assign oFault      = fault_q;
  assign oFaultPhase = phase_q;

endmodule

// File: tb/tb_bldcm_deadtime.sv
// -----------------------------------------------------------------------------
// tb_bldcm_deadtime
//   Directed bench for bldcm_deadtime with pInvertUh=1. Each step drives the
//   requests, queues the hand-derived expected outputs, then compares them one
//   cycle later. Gate vectors are written in logical terms {Uh,Ul,Vh,Vl,Wh,Wl}
//   and converted to physical levels with the bench's own polarity mask.
// -----------------------------------------------------------------------------
module tb_bldcm_deadtime;

  localparam logic [5:0] inv_mask = 6'b100000;  // only Uh inverted

  localparam logic [5:0] g_none = 6'b000000;
  localparam logic [5:0] u_h    = 6'b100000;
  localparam logic [5:0] u_l    = 6'b010000;
  localparam logic [5:0] v_h    = 6'b001000;
  localparam logic [5:0] v_l    = 6'b000100;
  localparam logic [5:0] w_h    = 6'b000010;
  localparam logic [5:0] w_l    = 6'b000001;

  logic       clk;
  logic       rst_n;
  logic [5:0] req;
  logic [7:0] dead;
  logic       clr;
  logic       uh, ul, vh, vl, wh, wl;
  logic       fault;
  logic [2:0] phase;

  typedef struct {
    string      tag;
    logic [9:0] val;  // {fault, phase[2:0], Uh,Ul,Vh,Vl,Wh,Wl}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bldcm_deadtime #(
    .pDeadWidth(8),
    .pInvertUh (1'b1)
  ) dut (
    .iClock     (clk),
    .iReset_n   (rst_n),
    .iUh        (req[5]),
    .iUl        (req[4]),
    .iVh        (req[3]),
    .iVl        (req[2]),
    .iWh        (req[1]),
    .iWl        (req[0]),
    .iDeadCycles(dead),
    .iFaultClear(clr),
    .oUh        (uh),
    .oUl        (ul),
    .oVh        (vh),
    .oVl        (vl),
    .oWh        (wh),
    .oWl        (wl),
    .oFault     (fault),
    .oFaultPhase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic push_exp(input string tag, input logic [3:0] f, input logic [5:0] gates);
    exp_t e;
    e.tag = tag;
    e.val = {f, gates ^ inv_mask};
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t       e;
    logic [9:0] obs;
    obs = {fault, phase, uh, ul, vh, vl, wh, wl};
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %b required <nothing queued>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed %b required %b", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one cycle of stimulus, expect the outputs after the next edge.
  task automatic step(input logic [5:0] r, input logic c, input logic [3:0] f,
                      input logic [5:0] gates, input string tag);
    req = r;
    clr = c;
    push_exp(tag, f, gates);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  // Compare without a clock edge (asynchronous reset behaviour).
  task automatic check_now(input logic [3:0] f, input logic [5:0] gates, input string tag);
    push_exp(tag, f, gates);
    pop_compare();
  endtask

  // Pulse reset between clock edges and check outputs while it is held.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    req = g_none;
    clr = 1'b0;
    #2 check_now(4'b0000, g_none, tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // 1. Reset: only oUh sits high (inverted pin).
    rst_n = 1'b0;
    req   = g_none;
    clr   = 1'b0;
    dead  = 8'd16;
    #12;
    check_now(4'b0000, g_none, "reset_levels");
    rst_n = 1'b1;

    // 2. D=16: first turn-on immediate, H->L waits 16 cycles with both off.
    step(u_h, 1'b0, 4'b0000, u_h, "d16_first_on");
    step(u_l, 1'b0, 4'b0000, g_none, "d16_h_off");
    for (int i = 1; i < 16; i++) step(u_l, 1'b0, 4'b0000, g_none, "d16_dead");
    step(u_l, 1'b0, 4'b0000, u_l, "d16_l_on");

    // 3. D=0 and D=1 both give exactly one dead cycle.
    dead = 8'd0;
    step(u_h, 1'b0, 4'b0000, g_none, "d0_dead");
    step(u_h, 1'b0, 4'b0000, u_h, "d0_on");
    dead = 8'd1;
    step(u_l, 1'b0, 4'b0000, g_none, "d1_dead");
    step(u_l, 1'b0, 4'b0000, u_l, "d1_on");
    step(u_h, 1'b0, 4'b0000, g_none, "d1_dead_back");
    step(u_h, 1'b0, 4'b0000, u_h, "d1_on_back");
    // Same-side re-enable inside a 16-cycle window is immediate.
    dead = 8'd16;
    step(g_none, 1'b0, 4'b0000, g_none, "same_side_release");
    step(u_h, 1'b0, 4'b0000, u_h, "same_side_reenable");
    step(g_none, 1'b0, 4'b0000, g_none, "u_release");

    // 4. D=8 fault handling.
    dead = 8'd8;
    step(w_h, 1'b0, 4'b0000, w_h, "w_on");
    step(v_h | v_l | w_h, 1'b0, 4'b1010, g_none, "fault_v");
    // Clear while U and V request 11: set wins and U's bit is ORed in.
    step(u_h | u_l | v_h | v_l | w_h, 1'b1, 4'b1011, g_none, "fault_clear_held");
    step(w_h, 1'b1, 4'b0000, g_none, "fault_cleared");
    for (int k = 2; k < 8; k++) step(w_h, 1'b0, 4'b0000, g_none, "fault_dead");
    step(w_h, 1'b0, 4'b0000, w_h, "w_on_after_fault");

    // 5. D=4 countdown unaffected by a mid-count change to 100.
    dead = 8'd4;
    step(w_l, 1'b0, 4'b0000, g_none, "d4_off");
    step(w_l, 1'b0, 4'b0000, g_none, "d4_dead1");
    dead = 8'd100;
    step(w_l, 1'b0, 4'b0000, g_none, "d4_dead2");
    step(w_l, 1'b0, 4'b0000, g_none, "d4_dead3");
    step(w_l, 1'b0, 4'b0000, w_l, "d4_on");
    step(w_h, 1'b0, 4'b0000, g_none, "d100_off");
    for (int k = 1; k < 100; k++) step(w_h, 1'b0, 4'b0000, g_none, "d100_dead");
    step(w_h, 1'b0, 4'b0000, w_h, "d100_on");

    // 6. Asynchronous reset mid-dead-time, then mid-fault.
    step(w_l, 1'b0, 4'b0000, g_none, "pre_rst_off");
    step(w_l, 1'b0, 4'b0000, g_none, "pre_rst_dead");
    async_reset("rst_mid_dead");
    step(w_l, 1'b0, 4'b0000, w_l, "first_on_after_rst");
    step(u_h | u_l, 1'b0, 4'b1001, g_none, "fault_u");
    async_reset("rst_mid_fault");
    step(u_h, 1'b0, 4'b0000, u_h, "first_on_after_fault_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bldcm_deadtime.md
Name: bldcm_deadtime

Overview:
- Downstream gate-drive conditioner between the BLDC drive core (six logical drive signals) and the inverter gate pins.
- Per phase (U/V/W), enforces a programmable dead time whenever drive moves from one side of a half-bridge to the other.
- Detects shoot-through requests (high and low requested together), latches a fault and forces all gates off until cleared.
- Applies per-pin output polarity. Upstream core is instantiated with all its invert parameters at 0.

Parameters:
pDeadWidth, 8, width of iDeadCycles and of each per-phase dead counter
pInvertUh, 1'b0, invert physical oUh (likewise pInvertUl, pInvertVh, pInvertVl, pInvertWh, pInvertWl, each default 1'b0)

Ports:
iClock  input  1  system clock; all logic on rising edge
iReset_n  input  1  asynchronous active-low reset
iUh, iUl, iVh, iVl, iWh, iWl  input  1 each  logical drive requests, active-high
iDeadCycles  input  pDeadWidth  dead time in clock cycles; sampled only when a counter loads
iFaultClear  input  1  level; clears the latched fault
oUh, oUl, oVh, oVl, oWh, oWl  output  1 each  physical gate drives (logical value XOR pInvert*)
oFault  output  1  shoot-through fault latched
oFaultPhase  output  3  sticky fault source mask {W,V,U}

Behaviour:
- Per-phase registers: rState {OFF, ON_H, ON_L}; rCnt (pDeadWidth); rLast {NONE, H, L, BOTH}.
- Outputs come straight from flops: logical high = (rState==ON_H), logical low = (rState==ON_L); physical = logical XOR pInvert*.
- Reset: all rState=OFF, rCnt=0, rLast=NONE, rFault=0, oFaultPhase=0. Every output is at its inactive level, i.e. oXx = pInvertXx.
- Request per phase req={h,l}, sampled every edge. Latency is 1 cycle unless dead-time gated.
- req 00: ON_H or ON_L -> OFF; rCnt<=iDeadCycles; rLast<=H or L respectively.
- req 10 in OFF -> ON_H when rLast in {NONE, H} or rCnt<=1; otherwise stay OFF.
- req 10 in ON_L -> OFF; rCnt<=iDeadCycles; rLast<=L.
- req 01: mirror image of req 10.
- Same-side re-enable (rLast equals the requested side) is immediate even while rCnt>0.
- Opposite-side turn-on gets max(iDeadCycles,1) cycles with both gates off. Examples: D=0 -> 1 cycle; D=1 -> 1 cycle; D=16 -> 16 cycles.
- rCnt decrements by 1 each cycle while nonzero, saturates at 0, and runs regardless of request or fault.
- A change to iDeadCycles mid-countdown does not affect a running counter.
- req 11 on any phase: rFault<=1 and oFaultPhase |= phase bit on that edge.
- On a fault edge, every phase: rState<=OFF; rCnt<=iDeadCycles; rLast<=BOTH. The fault edge loads counters even for phases already OFF.
- While rFault=1: all states held OFF, outputs inactive, counters keep decrementing.
- iFaultClear=1 with rFault=1 and no phase requesting 11: rFault<=0 and oFaultPhase<=0 on that edge. Normal operation resumes next edge.
- Set wins over clear: 11 together with iFaultClear keeps rFault=1 and ORs in the new phase bit.
- rLast=BOTH gates either side until rCnt<=1; after clear, turn-on still waits out any remaining dead time.
- oFault = rFault, registered.
- Asynchronous reset mid-dead-time or mid-fault returns everything to reset values immediately, without waiting for a clock edge.
- The three phases are fully independent except for the shared fault.

Test Plan:
1. Reset with pInvertUh=1, rest 0 -> oUh=1, other five outputs 0, oFault=0, oFaultPhase=0.
2. D=16: U req 10 from reset -> oUh=1 one cycle later. Then req 01 -> oUh=0 next edge, oUl=1 exactly 16 cycles later, never both high.
3. D=0 and D=1: H->L switch -> exactly 1 cycle with both off. H->00->H within the dead window -> oUh re-asserts 1 cycle after the request.
4. D=8: V req 11 while W on high side -> next edge oFault=1, oFaultPhase=3'b010, all six inactive. iFaultClear with V still 11 -> fault held. Clear after V=00 -> cleared; W req 10 turns on 8 cycles after the fault edge.
5. D=4 countdown, change iDeadCycles to 100 at cycle 2 -> turn-on still at 4 cycles. Next switch uses 100.
6. Assert iReset_n=0 mid-dead-time and during a latched fault -> outputs at inactive levels asynchronously. After release, a first turn-on is immediate.
